// File: rtl/pattern_fsm.sv
// Serial pattern detector: matches the last PAT_W accepted bits against a loaded pattern.
// Optional per-bit don't-care mask is enabled by defining PATTERN_FSM_MASK_EN.
module pattern_fsm #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
`ifdef PATTERN_FSM_MASK_EN
  input  logic [PAT_W-1:0] mask,
`endif
  input  logic             pat_load,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             armed
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [PAT_W-1:0]  PAT_ZERO  = {PAT_W{1'b0}};
  localparam logic [PAT_W-1:0]  PAT_ONES  = {PAT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_PEN   = CNT_MAX - CNT_ONE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   win_q, win_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [FILL_W-1:0]  fill_inc_s;
  logic [PAT_W-1:0]   mask_s;
  logic [PAT_W-1:0]   shift_s;
  logic               accept_s;
  logic               hit_s;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               armed_q, armed_d;

  // A zero mask bit makes that window position a don't-care.
  function automatic logic window_hit(input logic [PAT_W-1:0] win,
                                      input logic [PAT_W-1:0] pat,
                                      input logic [PAT_W-1:0] msk);
    return ((win ^ pat) & msk) == PAT_ZERO;
  endfunction

`ifdef PATTERN_FSM_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;
  assign mask_s = mask_q;
`else
  assign mask_s = PAT_ONES;
`endif

  // A load cycle swallows any coincident bit, so no match can occur on it.
  assign shift_s    = {win_q[PAT_W-2:0], in};
  assign accept_s   = in_valid & ~pat_load & (state_q != S_IDLE);
  assign hit_s      = accept_s & (fill_q >= FILL_LAST) & window_hit(shift_s, pat_q, mask_s);
  assign fill_inc_s = (fill_q == FILL_FULL) ? fill_q : (fill_q + FILL_ONE);

  // State and output registers
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      pat_q   <= PAT_ZERO;
      win_q   <= PAT_ZERO;
      fill_q  <= FILL_ZERO;
      out_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
      sat_q   <= 1'b0;
      armed_q <= 1'b0;
`ifdef PATTERN_FSM_MASK_EN
      mask_q  <= PAT_ONES;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      armed_q <= armed_d;
`ifdef PATTERN_FSM_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Next-state: load restarts the window; a non-overlapping match restarts it too
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    win_d   = win_q;
    fill_d  = fill_q;
`ifdef PATTERN_FSM_MASK_EN
    mask_d  = mask_q;
`endif
    if (pat_load) begin
      state_d = S_FILL;
      pat_d   = pattern;
      win_d   = PAT_ZERO;
      fill_d  = FILL_ZERO;
`ifdef PATTERN_FSM_MASK_EN
      mask_d  = mask;
`endif
    end else if (accept_s) begin
      if (hit_s && !overlap) begin
        state_d = S_FILL;
        win_d   = PAT_ZERO;
        fill_d  = FILL_ZERO;
      end else begin
        win_d   = shift_s;
        fill_d  = fill_inc_s;
        state_d = (fill_inc_s == FILL_FULL) ? S_RUN : S_FILL;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Outputs: a clear coinciding with a match leaves that match counted
  always_comb begin
    out_d   = hit_s;
    armed_d = (state_d != S_IDLE);
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clr_count) begin
      cnt_d = hit_s ? CNT_ONE : CNT_ZERO;
      sat_d = 1'b0;
    end else if (hit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
      sat_d = (cnt_q == CNT_PEN);
    end else begin
      cnt_d = cnt_q;
      sat_d = sat_q;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_pattern_fsm.sv
// Directed bench for pattern_fsm: a 4-bit/8-bit-count instance and a 2-bit/2-bit-count
// instance share the stream; each phase checks the instance it targets.
module tb_pattern_fsm;

  logic       clock = 1'b0;
  logic       reset_b;
  logic       in_s, in_valid_s, pat_load_s, overlap_s, clr_s;
  logic [3:0] pattern4_s;
  logic [1:0] pattern2_s;
  logic       out_a, sat_a, armed_a;
  logic [7:0] cnt_a;
  logic       out_b, sat_b, armed_b;
  logic [1:0] cnt_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  pattern_fsm #(.PAT_W(4), .CNT_W(8)) dut (
    .clock(clock), .reset_b(reset_b), .in(in_s), .in_valid(in_valid_s),
    .pattern(pattern4_s),
`ifdef PATTERN_FSM_MASK_EN
    .mask(4'b1111),
`endif
    .pat_load(pat_load_s), .overlap(overlap_s), .clr_count(clr_s),
    .out(out_a), .match_count(cnt_a), .count_sat(sat_a), .armed(armed_a)
  );

  pattern_fsm #(.PAT_W(2), .CNT_W(2)) dut2 (
    .clock(clock), .reset_b(reset_b), .in(in_s), .in_valid(in_valid_s),
    .pattern(pattern2_s),
`ifdef PATTERN_FSM_MASK_EN
    .mask(2'b11),
`endif
    .pat_load(pat_load_s), .overlap(overlap_s), .clr_count(clr_s),
    .out(out_b), .match_count(cnt_b), .count_sat(sat_b), .armed(armed_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic clr);
    @(negedge clock);
    in_s = b; in_valid_s = v; clr_s = clr; pat_load_s = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] p, input logic ovl, input logic clr,
                      input logic b, input logic v);
    @(negedge clock);
    pattern4_s = p; overlap_s = ovl; clr_s = clr; pat_load_s = 1'b1;
    in_s = b; in_valid_s = v;
    @(posedge clock);
    #1;
  endtask

  logic [6:0] seq7;
  logic [6:0] exp7;
  logic [3:0] seq4;
  logic [4:0] exp_out5;
  logic [4:0] exp_sat5;
  logic [9:0] exp_cnt5;

  initial begin
    reset_b = 1'b0;
    in_s = 1'b0; in_valid_s = 1'b0; pat_load_s = 1'b0; overlap_s = 1'b1; clr_s = 1'b0;
    pattern4_s = 4'b0000; pattern2_s = 2'b11;

    // Held in reset: bits are ignored
    seq4 = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step(seq4[i], 1'b1, 1'b0);
      chk("rst_out", out_a, 1'b0);
      chk("rst_armed", armed_a, 1'b0);
      chk("rst_cnt", cnt_a, 8'd0);
      chk("rst_sat", sat_a, 1'b0);
    end
    @(negedge clock);
    reset_b = 1'b1;

    // Out of reset with no pattern loaded: still idle
    for (int i = 3; i >= 0; i--) begin
      step(seq4[i], 1'b1, 1'b0);
      chk("idle_out", out_a, 1'b0);
      chk("idle_armed", armed_a, 1'b0);
      chk("idle_cnt", cnt_a, 8'd0);
    end

    // Overlapping matches: 1011011 -> pulses after bits 4 and 7
    load(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("load_armed", armed_a, 1'b1);
    chk("load_out", out_a, 1'b0);
    seq7 = 7'b1011011;
    exp7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      step(seq7[i], 1'b1, 1'b0);
      chk("ovl_out", out_a, exp7[i]);
    end
    chk("ovl_cnt", cnt_a, 8'd2);

    // Non-overlapping: window restarts after bit 4, so bit 7 gives no pulse
    load(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("novl_clr_cnt", cnt_a, 8'd0);
    exp7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      step(seq7[i], 1'b1, 1'b0);
      chk("novl_out", out_a, exp7[i]);
      chk("novl_armed", armed_a, 1'b1);
    end
    chk("novl_cnt", cnt_a, 8'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("novl_extra_out", out_a, 1'b0);
    chk("novl_extra_cnt", cnt_a, 8'd1);

    // A bit accepted on the load cycle is dropped
    load(4'b1011, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("drop_out0", out_a, 1'b0);
    chk("drop_cnt", cnt_a, 8'd1);
    seq4 = 4'b0110;
    for (int i = 3; i >= 1; i--) begin
      step(seq4[i], 1'b1, 1'b0);
      chk("drop_out", out_a, 1'b0);
    end

    // Idle cycles between bits are transparent
    load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    seq4 = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step(seq4[i], 1'b1, 1'b0);
      chk("gap_out", out_a, (i == 0) ? 1'b1 : 1'b0);
      for (int k = 0; k < 2; k++) begin
        step(1'b1, 1'b0, 1'b0);
        chk("gap_idle_out", out_a, 1'b0);
      end
    end
    chk("gap_cnt", cnt_a, 8'd2);

    // Saturation on the 2-bit counter instance: pattern 11, stream 11111
    load(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_load_cnt", cnt_b, 2'd0);
    exp_out5 = 5'b01111;
    exp_sat5 = 5'b00011;
    exp_cnt5 = {2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b1, 1'b0);
      chk("sat_out", out_b, exp_out5[i]);
      chk("sat_cnt", cnt_b, exp_cnt5[2*i +: 2]);
      chk("sat_flag", sat_b, exp_sat5[i]);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("clr_cnt", cnt_b, 2'd0);
    chk("clr_sat", sat_b, 1'b0);
    chk("clr_out", out_b, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_match_out", out_b, 1'b1);
    chk("clr_match_cnt", cnt_b, 2'd1);
    chk("clr_match_sat", sat_b, 1'b0);

    // Asynchronous reset mid-cycle during a partial match
    load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    seq4 = 4'b1010;
    for (int i = 3; i >= 1; i--) begin
      step(seq4[i], 1'b1, 1'b0);
      chk("mid_pre_out", out_a, 1'b0);
    end
    chk("mid_pre_armed", armed_a, 1'b1);
    chk("mid_pre_cnt2", cnt_b, 2'd1);
    #2;
    reset_b = 1'b0;
    #1;
    chk("mid_rst_out", out_a, 1'b0);
    chk("mid_rst_armed", armed_a, 1'b0);
    chk("mid_rst_armed2", armed_b, 1'b0);
    chk("mid_rst_cnt2", cnt_b, 2'd0);
    chk("mid_rst_sat2", sat_b, 1'b0);
    @(negedge clock);
    #2;
    reset_b = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_out", out_a, 1'b0);
    chk("post_rst_armed", armed_a, 1'b0);
    chk("post_rst_cnt", cnt_a, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
